// File: rtl/loop_replay_ctrl_pkg.sv
// Shared types and constants for the loop replay controller.
// Optional replay statistics are enabled by defining LOOP_REPLAY_STATS_EN.
package loop_replay_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StArmed   = 2'd1;
  localparam state_t StCapture = 2'd2;
  localparam state_t StReplay  = 2'd3;

endpackage

// File: rtl/loop_replay_ctrl_if.sv
// Front-end side bundle of the loop replay controller; master = pipeline, slave = controller.
// LOOP_REPLAY_STATS_EN adds the replay_count output.
interface loop_replay_ctrl_if;
  import loop_replay_ctrl_pkg::*;

  logic [INSTR_W-1:0] curr_PC;
  logic [INSTR_W-1:0] instruction;
  logic [INSTR_W-1:0] immediate;
  logic               mispredict;
  logic [INSTR_W-1:0] out_instruction;
  logic [INSTR_W-1:0] out_pc;
  logic               reuse_signal;
  logic               block_signal;
  logic               flush;
  logic [INSTR_W-1:0] new_pc;
`ifdef LOOP_REPLAY_STATS_EN
  logic [15:0]        replay_count;
`endif

  modport master (
    output curr_PC, instruction, immediate, mispredict,
    input  out_instruction, out_pc, reuse_signal, block_signal, flush, new_pc
`ifdef LOOP_REPLAY_STATS_EN
    , input replay_count
`endif
  );

  modport slave (
    input  curr_PC, instruction, immediate, mispredict,
    output out_instruction, out_pc, reuse_signal, block_signal, flush, new_pc
`ifdef LOOP_REPLAY_STATS_EN
    , output replay_count
`endif
  );

endinterface

// File: rtl/loop_buf.sv
// Loop body buffer: DEPTH x INSTR_W registers, one synchronous write, one combinational read.
// Contents are deliberately left unreset.
module loop_buf
  import loop_replay_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/loop_replay_ctrl.sv
// Replays short backward loops from a local buffer while blocking fetch.
// Define LOOP_REPLAY_STATS_EN to add the saturating replay_count output.
module loop_replay_ctrl
  import loop_replay_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic               clk,
  input logic               reset,
  loop_replay_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] start_q, start_d, br_q, br_d;
  logic [IDX_W-1:0]   last_q, last_d, rd_ptr_q, rd_ptr_d;
  logic               pend_q, pend_d;
  logic [INSTR_W-1:0] instr_q, instr_d, pc_q, pc_d, new_pc_q, new_pc_d;
  logic               reuse_q, reuse_d, block_q, block_d, flush_q, flush_d;

  logic               we;
  logic [IDX_W-1:0]   waddr, word_off;
  logic [INSTR_W-1:0] rdata, neg_imm;
  logic               is_br, cand, in_range;

  assign is_br    = bus.instruction[6:0] == OPC_BRANCH;
  assign neg_imm  = 32'd0 - bus.immediate;
  // Backward branch whose body (including the branch) fits in the buffer.
  assign cand     = is_br && bus.immediate[31] && (neg_imm <= 32'(DEPTH - 1));
  assign in_range = (bus.curr_PC >= start_q) && (bus.curr_PC <= br_q);
  assign word_off = bus.curr_PC[IDX_W+1:2] - start_q[IDX_W+1:2];

  loop_buf #(
    .DEPTH(DEPTH)
  ) u_loop_buf (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.instruction),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    br_d     = br_q;
    last_d   = last_q;
    rd_ptr_d = rd_ptr_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    new_pc_d = new_pc_q;
    reuse_d  = reuse_q;
    block_d  = block_q;
    we       = 1'b0;
    waddr    = word_off;
    // A mispredict seen during replay is turned into a flush one cycle later.
    flush_d  = pend_q;
    pend_d   = 1'b0;
    if (pend_q) begin
      new_pc_d = br_q + 32'd4;
      block_d  = 1'b0;
      reuse_d  = 1'b0;
    end

    if (bus.mispredict) begin
      pend_d  = (state_q == StReplay);
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cand) begin
            start_d = bus.curr_PC + {bus.immediate[29:0], 2'b00};
            br_d    = bus.curr_PC;
            last_d  = neg_imm[IDX_W-1:0];
            state_d = StArmed;
          end
        end
        StArmed: begin
          if (bus.curr_PC == start_q) begin
            we      = 1'b1;
            state_d = StCapture;
          end else if (!in_range) begin
            state_d = StIdle;
          end
        end
        StCapture: begin
          if (!in_range) begin
            state_d = StIdle;
          end else begin
            we = 1'b1;
            if (bus.curr_PC == br_q) begin
              state_d  = is_br ? StReplay : StIdle;
              rd_ptr_d = '0;
            end else if (is_br) begin
              state_d = StIdle;
            end
          end
        end
        StReplay: begin
          block_d  = 1'b1;
          reuse_d  = 1'b1;
          instr_d  = rdata;
          pc_d     = start_q + 32'({rd_ptr_q, 2'b00});
          rd_ptr_d = (rd_ptr_q == last_q) ? '0 : rd_ptr_q + IDX_W'(1);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      start_q  <= '0;
      br_q     <= '0;
      last_q   <= '0;
      rd_ptr_q <= '0;
      pend_q   <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      new_pc_q <= '0;
      reuse_q  <= 1'b0;
      block_q  <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      br_q     <= br_d;
      last_q   <= last_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      new_pc_q <= new_pc_d;
      reuse_q  <= reuse_d;
      block_q  <= block_d;
      flush_q  <= flush_d;
    end
  end

  assign bus.out_instruction = instr_q;
  assign bus.out_pc          = pc_q;
  assign bus.reuse_signal    = reuse_q;
  assign bus.block_signal    = block_q;
  assign bus.flush           = flush_q;
  assign bus.new_pc          = new_pc_q;

`ifdef LOOP_REPLAY_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reuse_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.replay_count = cnt_q;
`endif

endmodule

// File: tb/tb_loop_replay_ctrl.sv
// Self-checking bench for loop_replay_ctrl: directed vector table, corner sequences and
// randomized loops compared against a behavioural model.
module tb_loop_replay_ctrl;
  import loop_replay_ctrl_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int MIdle = 0, MArmed = 1, MCapture = 2, MReplay = 3;
  localparam logic [31:0] BR = 32'hFC00_0AE3;
  localparam logic [31:0] M3 = 32'hFFFF_FFFD;

  logic clk = 1'b0;
  logic reset = 1'b1;

  loop_replay_ctrl_if bus();

  loop_replay_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: the loop is a PC range plus an array of words; replay position is
  // a running index taken modulo the loop length.
  int          mode;
  logic [31:0] m_start, m_br;
  int          m_len, m_k;
  bit          m_pend;
  logic [31:0] m_body [DEPTH];
  logic [31:0] e_instr, e_pc, e_new;
  bit          e_block, e_reuse, e_flush;
  int          e_count;

  typedef struct {
    logic [31:0] pc, ins, imm;
    bit          mp, blk, reu, fl;
    logic [31:0] opc, oins, npc;
  } vec_t;
  vec_t vecs[13];

  logic [31:0] r_body [DEPTH+2];
  logic [31:0] w, base;
  int          len, abort_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = MIdle; m_pend = 0; m_k = 0;
    e_instr = 0; e_pc = 0; e_new = 0; e_block = 0; e_reuse = 0; e_flush = 0; e_count = 0;
  endtask

  task automatic model_step(input logic [31:0] pc, ins, imm, input bit mp);
    bit br, inr;
    int si, idx;
    br  = (ins[6:0] == 7'b1100011);
    inr = (pc >= m_start) && (pc <= m_br);
    si  = int'($signed(imm));
    e_flush = 0;
    if (m_pend) begin
      e_flush = 1; e_new = m_br + 32'd4; e_block = 0; e_reuse = 0; m_pend = 0;
    end
    if (mode == MReplay && !mp) begin
      e_block = 1; e_reuse = 1;
      e_pc    = m_start + 32'(4 * (m_k % m_len));
      e_instr = m_body[m_k % m_len];
      m_k++;
    end
    if (mp) begin
      if (mode == MReplay) m_pend = 1;
      mode = MIdle;
    end else begin
      case (mode)
        MIdle: if (br && si < 0 && si >= 1 - int'(DEPTH)) begin
          m_start = pc + 32'(4 * si); m_br = pc; m_len = 1 - si; mode = MArmed;
        end
        MArmed: begin
          if (pc == m_start) begin
            m_body[0] = ins; mode = MCapture;
          end else if (!inr) mode = MIdle;
        end
        MCapture: begin
          if (!inr) mode = MIdle;
          else begin
            idx = int'((pc - m_start) / 4);
            m_body[idx] = ins;
            if (pc == m_br) begin
              if (br) begin mode = MReplay; m_k = 0; end
              else mode = MIdle;
            end else if (br) mode = MIdle;
          end
        end
        default: ;
      endcase
    end
    if (e_reuse && e_count < 65535) e_count++;
  endtask

  task automatic compare_all();
    chk("block_signal", bus.block_signal, e_block);
    chk("reuse_signal", bus.reuse_signal, e_reuse);
    chk("flush", bus.flush, e_flush);
    chk("out_pc", bus.out_pc, e_pc);
    chk("out_instruction", bus.out_instruction, e_instr);
    chk("new_pc", bus.new_pc, e_new);
`ifdef LOOP_REPLAY_STATS_EN
    chk("replay_count", 32'(bus.replay_count), e_count);
`endif
  endtask

  task automatic step(input logic [31:0] pc, ins, imm, input bit mp);
    bus.curr_PC = pc; bus.instruction = ins; bus.immediate = imm; bus.mispredict = mp;
    @(posedge clk);
    model_step(pc, ins, imm, mp);
    #1;
    compare_all();
  endtask

  initial begin
    bus.curr_PC = 0; bus.instruction = 0; bus.immediate = 0; bus.mispredict = 0;
    for (int i = 0; i < DEPTH; i++) m_body[i] = 0;
    m_start = 0; m_br = 0; m_len = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    compare_all();
    step(32'h40, 32'h13, 0, 1);
    step(32'h44, 32'h13, 0, 0);
    chk("idle_misp_no_flush", bus.flush, 0);

    vecs[0]  = '{32'h10C, BR, M3, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{32'h100, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{32'h104, 32'h14, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{32'h108, 32'h15, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{32'h10C, BR, M3, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{32'h10C, BR, M3, 0, 1, 1, 0, 32'h100, 32'h13, 0};
    vecs[6]  = '{32'h10C, BR, M3, 0, 1, 1, 0, 32'h104, 32'h14, 0};
    vecs[7]  = '{32'h10C, BR, M3, 0, 1, 1, 0, 32'h108, 32'h15, 0};
    vecs[8]  = '{32'h10C, BR, M3, 0, 1, 1, 0, 32'h10C, BR, 0};
    vecs[9]  = '{32'h10C, BR, M3, 0, 1, 1, 0, 32'h100, 32'h13, 0};
    vecs[10] = '{32'h10C, BR, M3, 1, 1, 1, 0, 32'h100, 32'h13, 0};
    vecs[11] = '{32'h110, 32'h13, 0, 0, 0, 0, 1, 32'h100, 32'h13, 32'h110};
    vecs[12] = '{32'h114, 32'h13, 0, 0, 0, 0, 0, 32'h100, 32'h13, 32'h110};
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].pc, vecs[i].ins, vecs[i].imm, vecs[i].mp);
      chk($sformatf("tbl%0d_block", i), bus.block_signal, vecs[i].blk);
      chk($sformatf("tbl%0d_reuse", i), bus.reuse_signal, vecs[i].reu);
      chk($sformatf("tbl%0d_flush", i), bus.flush, vecs[i].fl);
      chk($sformatf("tbl%0d_out_pc", i), bus.out_pc, vecs[i].opc);
      chk($sformatf("tbl%0d_out_instr", i), bus.out_instruction, vecs[i].oins);
      chk($sformatf("tbl%0d_new_pc", i), bus.new_pc, vecs[i].npc);
    end

    // Oversize loop: 17 words never qualifies.
    step(32'h200, 32'h63, 32'hFFFF_FFF0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 17; i++) begin
        step(32'h1C0 + 32'(4 * i), (i == 16) ? 32'h63 : 32'h13,
             (i == 16) ? 32'hFFFF_FFF0 : 0, 0);
        chk("oversize_block", bus.block_signal, 0);
      end
    end

    // Capture abort, then a plain pass only re-arms.
    step(32'h10C, BR, M3, 0);
    step(32'h100, 32'h13, 0, 0);
    step(32'h104, 32'h14, 0, 0);
    step(32'h300, 32'h13, 0, 0);
    step(32'h100, 32'h13, 0, 0);
    step(32'h104, 32'h14, 0, 0);
    step(32'h108, 32'h15, 0, 0);
    step(32'h10C, BR, M3, 0);
    step(32'h110, 32'h13, 0, 0);
    chk("abort_block", bus.block_signal, 0);
    step(32'h114, 32'h13, 0, 0);
    chk("abort_block2", bus.block_signal, 0);

    // Mispredict together with the candidate: nothing latched.
    step(32'h10C, BR, M3, 1);
    step(32'h100, 32'h13, 0, 0);
    step(32'h104, 32'h14, 0, 0);
    step(32'h108, 32'h15, 0, 0);
    step(32'h10C, BR, M3, 0);
    step(32'h10C, BR, M3, 0);
    chk("misp_cand_block", bus.block_signal, 0);
    step(32'h110, 32'h13, 0, 0);

    // Asynchronous reset in the middle of replay.
    step(32'h10C, BR, M3, 0);
    for (int i = 0; i < 4; i++) step(32'h100 + 32'(4 * i), (i == 3) ? BR : 32'h13 + 32'(i), M3, 0);
    step(32'h10C, BR, M3, 0);
    step(32'h10C, BR, M3, 0);
    chk("pre_rst_block", bus.block_signal, 1);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 reset = 1'b0;
    step(32'h110, 32'h13, 0, 0);
    chk("rst_no_flush", bus.flush, 0);
    step(32'h114, 32'h13, 0, 0);
    chk("rst_no_flush2", bus.flush, 0);

    // Randomized loops against the model.
    for (int ep = 0; ep < 40; ep++) begin
      len  = $urandom_range(2, DEPTH + 2);
      base = 32'h1000 + ($urandom_range(0, 63) << 8);
      for (int i = 0; i < len; i++) begin
        w = $urandom();
        r_body[i] = {w[31:7], 7'h13};
      end
      w = $urandom();
      r_body[len-1] = {w[31:7], 7'h63};
      if ($urandom_range(0, 9) == 0) r_body[$urandom_range(0, len - 2)][6:0] = 7'h63;
      abort_i = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len - 1) : -1;
      for (int p = 0; p < 3; p++) begin
        for (int i = 0; i < len; i++) begin
          if (p == 1 && i == abort_i) step(32'h8000, 32'h13, 0, 0);
          step(base + 32'(4 * i), r_body[i],
               (i == len - 1) ? 32'(1 - len) : 32'($urandom_range(0, 8)),
               $urandom_range(0, 29) == 0);
        end
      end
      repeat ($urandom_range(1, 2 * len + 3))
        step(base + 32'(4 * (len - 1)), r_body[len-1], 32'(1 - len), 0);
      step(base + 32'(4 * (len - 1)), r_body[len-1], 32'(1 - len), 1);
      step(base + 32'(4 * len), 32'h13, 0, 0);
      step(base + 32'(4 * len) + 32'd4, 32'h13, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
